// File: rtl/cpu_run_ctrl.sv
// Program loader and run sequencer for the 8-bit accumulator CPU: owns program memory,
// loads it from a byte stream, boots and supervises a run, captures ACC on halt.
module cpu_run_ctrl #(
  parameter int DEPTH      = 256,
  parameter int MAX_CYCLES = 1024,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_start_i,
  input  logic             load_valid_i,
  input  logic [7:0]       load_data_i,
  input  logic             load_last_i,
  output logic             load_ready_o,
  input  logic             run_start_i,
  input  logic             abort_i,
  input  logic [7:0]       cpu_pc_i,
  input  logic             cpu_halted_i,
  input  logic [7:0]       cpu_acc_i,
  output logic             cpu_reset_o,
  output logic [7:0]       cpu_instr_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic             load_err_o,
  output logic [7:0]       result_o,
  output logic [8:0]       load_count_o,
  output logic [CNT_W-1:0] cycle_count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_BOOT  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [8:0]       load_count_q, load_count_d;
  logic             load_err_q, load_err_d;
  logic [7:0]       result_q, result_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             mem_we_s;
  logic [AW-1:0]    rd_addr_s;
  logic [7:0]       mem_q [DEPTH];

  // Next-state and datapath updates; abort overrides every state's decision.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    load_count_d  = load_count_q;
    load_err_d    = load_err_q;
    result_d      = result_q;
    cycle_count_d = cycle_count_q;
    mem_we_s      = 1'b0;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_FAULT: begin
          if (load_start_i) begin
            state_d      = S_LOAD;
            ptr_d        = '0;
            load_count_d = 9'd0;
            load_err_d   = 1'b0;
          end else if (run_start_i) begin
            state_d = S_BOOT;
          end else begin
            state_d = state_q;
          end
        end
        S_LOAD: begin
          if (load_valid_i) begin
            mem_we_s     = 1'b1;
            ptr_d        = ptr_q + {{(AW-1){1'b0}}, 1'b1};
            load_count_d = load_count_q + 9'd1;
            if (load_last_i) begin
              state_d = S_IDLE;
            end else if (ptr_q == AW'(DEPTH - 1)) begin
              // Memory full without a terminating byte: stop accepting.
              state_d    = S_IDLE;
              load_err_d = 1'b1;
            end else begin
              state_d = S_LOAD;
            end
          end else begin
            state_d = S_LOAD;
          end
        end
        S_BOOT: begin
          cycle_count_d = '0;
          result_d      = 8'h00;
          state_d       = S_RUN;
        end
        S_RUN: begin
          cycle_count_d = cycle_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cpu_halted_i) begin
            state_d  = S_DONE;
            result_d = cpu_acc_i;
          end else if (cycle_count_q == CNT_W'(MAX_CYCLES - 1)) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_RUN;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Control and status registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      load_count_q  <= 9'd0;
      load_err_q    <= 1'b0;
      result_q      <= 8'h00;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      load_count_q  <= load_count_d;
      load_err_q    <= load_err_d;
      result_q      <= result_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // Program memory write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_s && !reset_i) begin
      mem_q[ptr_q] <= load_data_i;
    end
  end

  assign rd_addr_s     = AW'(cpu_pc_i);
  assign cpu_instr_o   = (state_q == S_LOAD) ? 8'h00 : mem_q[rd_addr_s];
  assign cpu_reset_o   = !((state_q == S_RUN) || (state_q == S_DONE));
  assign load_ready_o  = (state_q == S_LOAD);
  assign busy_o        = (state_q == S_LOAD) || (state_q == S_BOOT) || (state_q == S_RUN);
  assign done_o        = (state_q == S_DONE);
  assign timeout_o     = (state_q == S_FAULT);
  assign load_err_o    = load_err_q;
  assign result_o      = result_q;
  assign load_count_o  = load_count_q;
  assign cycle_count_o = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a tiny accumulator-CPU model
// (Ax = load imm, 7x = branch-if-zero, Fx = halt, one idle cycle after reset).
module tb_cpu_run_ctrl;

  logic        clk_s = 1'b0;
  logic        reset_s, load_start_s, load_valid_s, load_last_s, run_start_s, abort_s;
  logic [7:0]  load_data_s;
  logic        load_ready_s, cpu_reset_s, busy_s, done_s, timeout_s, load_err_s;
  logic [7:0]  cpu_pc_s, cpu_instr_s, result_s;
  logic [8:0]  load_count_s;
  logic [15:0] cycle_count_s;
  logic        pc_force_en_s;
  logic [7:0]  pc_force_s;
  logic [7:0]  m_pc_r, m_acc_r;
  logic        m_halted_r, m_started_r;
  logic        rst_seen_s;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk_s = ~clk_s;

  cpu_run_ctrl #(.DEPTH(16), .MAX_CYCLES(32), .CNT_W(16)) dut (
    .clk_i(clk_s), .reset_i(reset_s),
    .load_start_i(load_start_s), .load_valid_i(load_valid_s), .load_data_i(load_data_s),
    .load_last_i(load_last_s), .load_ready_o(load_ready_s),
    .run_start_i(run_start_s), .abort_i(abort_s),
    .cpu_pc_i(cpu_pc_s), .cpu_halted_i(m_halted_r), .cpu_acc_i(m_acc_r),
    .cpu_reset_o(cpu_reset_s), .cpu_instr_o(cpu_instr_s),
    .busy_o(busy_s), .done_o(done_s), .timeout_o(timeout_s), .load_err_o(load_err_s),
    .result_o(result_s), .load_count_o(load_count_s), .cycle_count_o(cycle_count_s)
  );

  assign cpu_pc_s = pc_force_en_s ? pc_force_s : m_pc_r;

  // CPU model: held in reset by the controller, then one idle cycle before fetching.
  always @(posedge clk_s) begin
    if (cpu_reset_s) begin
      m_pc_r <= 8'h00; m_acc_r <= 8'h00; m_halted_r <= 1'b0; m_started_r <= 1'b0;
    end else if (!m_started_r) begin
      m_started_r <= 1'b1;
    end else if (!m_halted_r) begin
      case (cpu_instr_s[7:4])
        4'hA:    begin m_acc_r <= {4'h0, cpu_instr_s[3:0]}; m_pc_r <= m_pc_r + 8'd1; end
        4'h7:    m_pc_r <= (m_acc_r == 8'h00) ? {4'h0, cpu_instr_s[3:0]} : m_pc_r + 8'd1;
        4'hF:    m_halted_r <= 1'b1;
        default: m_pc_r <= m_pc_r + 8'd1;
      endcase
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_s);
    #1;
  endtask

  task automatic load2(input logic [7:0] b0, input logic [7:0] b1);
    load_start_s = 1'b1; tick(); load_start_s = 1'b0;
    load_valid_s = 1'b1; load_data_s = b0; load_last_s = 1'b0; tick();
    load_data_s = b1; load_last_s = 1'b1; tick();
    load_valid_s = 1'b0; load_last_s = 1'b0;
  endtask

  // Start a run, check the single BOOT cycle, then wait (bounded) for DONE or FAULT.
  task automatic run_wait(input string tag);
    rst_seen_s = 1'b0;
    run_start_s = 1'b1; tick(); run_start_s = 1'b0;
    check_val({tag, "_boot"}, {cpu_reset_s, busy_s}, 2'b11);
    tick();
    check_val({tag, "_run_rst"}, {cpu_reset_s, busy_s}, 2'b01);
    for (int i = 0; i < 100; i++) begin
      if (done_s || timeout_s) break;
      rst_seen_s = rst_seen_s | cpu_reset_s;
      tick();
    end
    check_val({tag, "_ended"}, done_s | timeout_s, 1'b1);
  endtask

  initial begin
    reset_s = 1'b1; load_start_s = 1'b0; load_valid_s = 1'b0; load_last_s = 1'b0;
    load_data_s = 8'h00; run_start_s = 1'b0; abort_s = 1'b0;
    pc_force_en_s = 1'b0; pc_force_s = 8'h00; rst_seen_s = 1'b0;
    tick(); tick();
    reset_s = 1'b0;
    check_val("rst_flags", {cpu_reset_s, busy_s, done_s, timeout_s, load_err_s, load_ready_s}, 6'b100000);
    check_val("rst_counts", {result_s, load_count_s, cycle_count_s}, 33'd0);

    // Test 1: A3,F0 -> result 3 after 4 RUN cycles.
    load2(8'hA3, 8'hF0);
    check_val("t1_load_count", load_count_s, 9'd2);
    run_wait("t1");
    check_val("t1_done", {done_s, timeout_s, busy_s}, 3'b100);
    check_val("t1_result", result_s, 8'h03);
    check_val("t1_cycles", cycle_count_s, 16'd4);
    check_val("t1_rst_low", {rst_seen_s, cpu_reset_s}, 2'b00);

    // Test 6: valid toggling, NOP fed during LOAD, readback through cpu_pc.
    load_start_s = 1'b1; tick(); load_start_s = 1'b0;
    pc_force_en_s = 1'b1; pc_force_s = 8'h00; #1;
    check_val("t6_nop_in_load", cpu_instr_s, 8'h00);
    for (int i = 0; i < 4; i++) begin
      load_valid_s = 1'b1; load_data_s = 8'h11 * (i + 1); load_last_s = (i == 3); tick();
      load_valid_s = 1'b0; load_last_s = 1'b0; tick();
    end
    check_val("t6_load_count", load_count_s, 9'd4);
    check_val("t6_idle", {busy_s, load_ready_s}, 2'b00);
    for (int i = 0; i < 4; i++) begin
      pc_force_s = 8'(i); #1;
      check_val("t6_readback", cpu_instr_s, 8'h11 * (i + 1));
    end
    pc_force_en_s = 1'b0;

    // Test 4: both starts together -> LOAD wins.
    load_start_s = 1'b1; run_start_s = 1'b1; tick();
    load_start_s = 1'b0; run_start_s = 1'b0;
    check_val("t4_load", {load_ready_s, busy_s, cpu_reset_s, done_s}, 4'b1110);
    load_valid_s = 1'b1; load_data_s = 8'h55; load_last_s = 1'b1; tick();
    load_valid_s = 1'b0; load_last_s = 1'b0;
    check_val("t4_count", load_count_s, 9'd1);

    // Test 2: A0,71 loops forever -> FAULT after 32 RUN cycles.
    load2(8'hA0, 8'h71);
    run_wait("t2");
    check_val("t2_fault", {timeout_s, done_s, cpu_reset_s}, 3'b101);
    check_val("t2_cycles", cycle_count_s, 16'd32);

    // Test 5: abort five cycles into RUN; counters held, then rerun test 1.
    run_start_s = 1'b1; tick(); run_start_s = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) tick();
    check_val("t5_running", {busy_s, cycle_count_s}, {1'b1, 16'd5});
    abort_s = 1'b1; tick(); abort_s = 1'b0;
    check_val("t5_idle", {busy_s, cpu_reset_s, done_s, timeout_s}, 4'b0100);
    tick();
    check_val("t5_held", {result_s, cycle_count_s}, {8'h00, 16'd5});
    load2(8'hA3, 8'hF0);
    run_wait("t5r");
    check_val("t5_rerun", {done_s, result_s, cycle_count_s}, {1'b1, 8'h03, 16'd4});

    // Test 3: 17 bytes without last into a 16-entry memory.
    load_start_s = 1'b1; tick(); load_start_s = 1'b0;
    for (int i = 0; i < 17; i++) begin
      check_val("t3_ready", load_ready_s, (i < 16) ? 1'b1 : 1'b0);
      load_valid_s = 1'b1; load_data_s = 8'h40 + 8'(i); load_last_s = 1'b0; tick();
    end
    load_valid_s = 1'b0;
    check_val("t3_err", {load_err_s, load_count_s}, {1'b1, 9'd16});
    pc_force_en_s = 1'b1;
    pc_force_s = 8'h0F; #1; check_val("t3_last_addr", cpu_instr_s, 8'h4F);
    pc_force_s = 8'h10; #1; check_val("t3_pc_wrap", cpu_instr_s, 8'h40);
    pc_force_en_s = 1'b0;
    load_start_s = 1'b1; tick(); load_start_s = 1'b0;
    check_val("t3_err_clr", {load_err_s, load_count_s}, {1'b0, 9'd0});
    load_valid_s = 1'b1; load_data_s = 8'hF0; load_last_s = 1'b1; tick();
    load_valid_s = 1'b0; load_last_s = 1'b0;
    check_val("t3_reload", {load_err_s, load_count_s, busy_s}, {1'b0, 9'd1, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
